// File: rtl/dijkstra_axil_regs.sv
// AXI4-Lite register file for the Dijkstra core, with a core-side write port into the same registers.
// Optional: define DIJKSTRA_AXIL_SLVERR_EN to answer addresses >= NUM_REGS*4 with SLVERR.
module dijkstra_axil_regs #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6,
  parameter int NUM_REGS   = 4
) (
  input  logic                           S_AXI_ACLK,
  input  logic                           S_AXI_ARESETN,
  input  logic [ADDR_WIDTH-1:0]          S_AXI_AWADDR,
  input  logic [2:0]                     S_AXI_AWPROT,
  input  logic                           S_AXI_AWVALID,
  output logic                           S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]          S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
  input  logic                           S_AXI_WVALID,
  output logic                           S_AXI_WREADY,
  output logic [1:0]                     S_AXI_BRESP,
  output logic                           S_AXI_BVALID,
  input  logic                           S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]          S_AXI_ARADDR,
  input  logic [2:0]                     S_AXI_ARPROT,
  input  logic                           S_AXI_ARVALID,
  output logic                           S_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]          S_AXI_RDATA,
  output logic [1:0]                     S_AXI_RRESP,
  output logic                           S_AXI_RVALID,
  input  logic                           S_AXI_RREADY,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  output logic [NUM_REGS-1:0]            reg_wr_pulse,
  input  logic                           hw_we,
  input  logic [$clog2(NUM_REGS)-1:0]    hw_idx,
  input  logic [DATA_WIDTH-1:0]          hw_wdata
);

  localparam int IDXW = $clog2(NUM_REGS);
  localparam int STRBW = DATA_WIDTH / 8;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_q, regs_d;
  logic                  aw_full_q, aw_full_d;
  logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
  logic                  w_full_q, w_full_d;
  logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
  logic [STRBW-1:0]      w_strb_q, w_strb_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [NUM_REGS-1:0]   pulse_q, pulse_d;

  logic                  awready, wready, arready;
  logic                  aw_hs, w_hs, aw_have, w_have, commit, ar_hs;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [STRBW-1:0]      wr_strb;
  logic [IDXW-1:0]       wr_idx, rd_idx;
  logic                  wr_oor, rd_oor;
  logic                  unused_inputs;

  // Readies are gated by reset so they read low while reset is held.
  assign awready = S_AXI_ARESETN & !aw_full_q;
  assign wready  = S_AXI_ARESETN & !w_full_q;
  assign arready = S_AXI_ARESETN & (!rvalid_q | S_AXI_RREADY);

  assign aw_hs   = S_AXI_AWVALID & awready;
  assign w_hs    = S_AXI_WVALID & wready;
  assign aw_have = aw_full_q | aw_hs;
  assign w_have  = w_full_q | w_hs;
  assign wr_addr = aw_full_q ? aw_addr_q : S_AXI_AWADDR;
  assign wr_data = w_full_q ? w_data_q : S_AXI_WDATA;
  assign wr_strb = w_full_q ? w_strb_q : S_AXI_WSTRB;
  assign commit  = aw_have & w_have & (!bvalid_q | S_AXI_BREADY);
  assign ar_hs   = S_AXI_ARVALID & arready;
  assign wr_idx  = wr_addr[2 +: IDXW];
  assign rd_idx  = S_AXI_ARADDR[2 +: IDXW];

`ifdef DIJKSTRA_AXIL_SLVERR_EN
  assign wr_oor = (32'(wr_addr) >= 32'(NUM_REGS * 4));
  assign rd_oor = (32'(S_AXI_ARADDR) >= 32'(NUM_REGS * 4));
`else
  assign wr_oor = 1'b0;
  assign rd_oor = 1'b0;
`endif

  assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, wr_addr, S_AXI_ARADDR};

  always_comb begin
    regs_d = regs_q;
    // Core write first so that an AXI commit to the same register overrides it.
    if (hw_we) regs_d[hw_idx] = hw_wdata;
    if (commit && !wr_oor) begin
      for (int k = 0; k < STRBW; k++) begin
        if (wr_strb[k]) regs_d[wr_idx][8*k +: 8] = wr_data[8*k +: 8];
      end
    end

    pulse_d = '0;
    if (commit && !wr_oor) pulse_d[wr_idx] = 1'b1;

    aw_full_d = commit ? 1'b0 : aw_have;
    aw_addr_d = aw_hs ? S_AXI_AWADDR : aw_addr_q;
    w_full_d  = commit ? 1'b0 : w_have;
    w_data_d  = w_hs ? S_AXI_WDATA : w_data_q;
    w_strb_d  = w_hs ? S_AXI_WSTRB : w_strb_q;

    bvalid_d = bvalid_q & !S_AXI_BREADY;
    bresp_d  = bresp_q;
    if (commit) begin
      bvalid_d = 1'b1;
      bresp_d  = wr_oor ? RESP_SLVERR : RESP_OKAY;
    end

    // Reads sample the pre-edge register state, so a same-edge write is not visible.
    rvalid_d = rvalid_q & !S_AXI_RREADY;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_oor ? '0 : regs_q[rd_idx];
      rresp_d  = rd_oor ? RESP_SLVERR : RESP_OKAY;
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      regs_q    <= '0;
      aw_full_q <= 1'b0;
      aw_addr_q <= '0;
      w_full_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= '0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= '0;
      pulse_q   <= '0;
    end else begin
      regs_q    <= regs_d;
      aw_full_q <= aw_full_d;
      aw_addr_q <= aw_addr_d;
      w_full_q  <= w_full_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      pulse_q   <= pulse_d;
    end
  end

  assign S_AXI_AWREADY = awready;
  assign S_AXI_WREADY  = wready;
  assign S_AXI_ARREADY = arready;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign reg_q         = regs_q;
  assign reg_wr_pulse  = pulse_q;

endmodule

// File: tb/tb_dijkstra_axil_regs.sv
// Bench for dijkstra_axil_regs: a directed vector table, hand-built multi-cycle sequences,
// and randomized AXI/core traffic checked against a transaction-level register model.
`timescale 1ns/1ps
module tb_dijkstra_axil_regs;
  localparam int NR = 4;
  localparam logic [1:0] OKAY = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic resetN;
  logic [5:0] awAddr, arAddr;
  logic awValid, awReady, wValid, wReady, bValid, bReady, arValid, arReady, rValid, rReady;
  logic [31:0] wData, rData;
  logic [3:0] wStrb;
  logic [1:0] bResp, rResp;
  logic [NR*32-1:0] regQ;
  logic [NR-1:0] wrPulse;
  logic hwWe;
  logic [1:0] hwIdx;
  logic [31:0] hwWdata;

  dijkstra_axil_regs #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .NUM_REGS(NR)) dut (
    .S_AXI_ACLK(clock), .S_AXI_ARESETN(resetN),
    .S_AXI_AWADDR(awAddr), .S_AXI_AWPROT(3'b000), .S_AXI_AWVALID(awValid), .S_AXI_AWREADY(awReady),
    .S_AXI_WDATA(wData), .S_AXI_WSTRB(wStrb), .S_AXI_WVALID(wValid), .S_AXI_WREADY(wReady),
    .S_AXI_BRESP(bResp), .S_AXI_BVALID(bValid), .S_AXI_BREADY(bReady),
    .S_AXI_ARADDR(arAddr), .S_AXI_ARPROT(3'b000), .S_AXI_ARVALID(arValid), .S_AXI_ARREADY(arReady),
    .S_AXI_RDATA(rData), .S_AXI_RRESP(rResp), .S_AXI_RVALID(rValid), .S_AXI_RREADY(rReady),
    .reg_q(regQ), .reg_wr_pulse(wrPulse),
    .hw_we(hwWe), .hw_idx(hwIdx), .hw_wdata(hwWdata)
  );

  typedef struct {
    bit          isWrite;
    logic [5:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          awDelay;
    int          wDelay;
    int          xDelay;
    logic [1:0]  expResp;
    logic [31:0] expData;
    logic [3:0]  expPulse;
  } vec_t;

  vec_t vecs[$];
  int checkCount = 0;
  int passCount = 0;
  int pulseSeen[NR];
  int pulseExp[NR];
  logic [31:0] model[NR];

  // Counts every cycle each pulse bit is high, so stretched or repeated pulses show up.
  always @(negedge clock) begin
    for (int i = 0; i < NR; i++) if (wrPulse[i]) pulseSeen[i]++;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got time limit, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] regOf(input int i);
    return regQ[32*i +: 32];
  endfunction

  function automatic int modelIdx(input logic [5:0] addr);
    return (int'(addr) / 4) % NR;
  endfunction

  function automatic bit modelOor(input logic [5:0] addr);
`ifdef DIJKSTRA_AXIL_SLVERR_EN
    return int'(addr) >= NR * 4;
`else
    return 1'b0;
`endif
  endfunction

  function automatic vec_t mkWrite(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                                   input int awD, input int wD, input int bD,
                                   input logic [1:0] er, input logic [3:0] ep);
    vec_t v;
    v.isWrite = 1'b1; v.addr = a; v.data = d; v.strb = s;
    v.awDelay = awD; v.wDelay = wD; v.xDelay = bD;
    v.expResp = er; v.expData = '0; v.expPulse = ep;
    return v;
  endfunction

  function automatic vec_t mkRead(input logic [5:0] a, input int rD, input logic [1:0] er,
                                  input logic [31:0] ed);
    vec_t v;
    v.isWrite = 1'b0; v.addr = a; v.data = '0; v.strb = '0;
    v.awDelay = 0; v.wDelay = 0; v.xDelay = rD;
    v.expResp = er; v.expData = ed; v.expPulse = '0;
    return v;
  endfunction

  task automatic axiWrite(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int awDelay, input int wDelay, input int bDelay,
                          output logic [1:0] resp, output logic [3:0] pulse);
    bit awDone, wDone, awHs, wHs;
    int cyc;
    awDone = 0; wDone = 0; cyc = 0;
    resp = 2'b11; pulse = '0;
    awAddr = addr; wData = data; wStrb = strb; bReady = 1'b0;
    while (!(awDone && wDone) && cyc < 40) begin
      awValid = !awDone && cyc >= awDelay;
      wValid = !wDone && cyc >= wDelay;
      #1;
      awHs = awValid && awReady;
      wHs = wValid && wReady;
      tick();
      awDone = awDone | awHs;
      wDone = wDone | wHs;
      cyc++;
    end
    awValid = 1'b0; wValid = 1'b0;
    if (!(awDone && wDone)) begin
      checkOutput("write_accept_timeout", 32'({awDone, wDone}), 32'h3);
      return;
    end
    checkOutput("bvalid_latency", 32'(bValid), 32'h1);
    cyc = 0;
    while (!bValid && cyc < 20) begin tick(); cyc++; end
    if (!bValid) begin
      checkOutput("bvalid_timeout", 32'(bValid), 32'h1);
      return;
    end
    resp = bResp;
    pulse = wrPulse;
    for (int i = 0; i < bDelay; i++) begin
      tick();
      checkOutput("b_hold", 32'({bValid, bResp}), 32'({1'b1, resp}));
    end
    bReady = 1'b1;
    tick();
    bReady = 1'b0;
    checkOutput("bvalid_drop", 32'(bValid), 32'h0);
  endtask

  task automatic axiRead(input logic [5:0] addr, input int rDelay,
                         output logic [31:0] data, output logic [1:0] resp);
    bit hs;
    int cyc;
    hs = 0; cyc = 0; data = '0; resp = 2'b11;
    arAddr = addr; arValid = 1'b1; rReady = 1'b0;
    while (!hs && cyc < 20) begin
      #1;
      hs = arReady;
      tick();
      cyc++;
    end
    arValid = 1'b0;
    if (!hs) begin
      checkOutput("ar_timeout", 32'(arReady), 32'h1);
      return;
    end
    checkOutput("rvalid_latency", 32'(rValid), 32'h1);
    data = rData;
    resp = rResp;
    for (int i = 0; i < rDelay; i++) begin
      tick();
      checkOutput("r_hold", {rData[31:2], rResp}, {data[31:2], resp});
      checkOutput("r_hold_data", rData, data);
    end
    rReady = 1'b1;
    tick();
    rReady = 1'b0;
    checkOutput("rvalid_drop", 32'(rValid), 32'h0);
  endtask

  task automatic applyStimulus(input vec_t v, input int n);
    logic [1:0] resp;
    logic [3:0] pulse;
    logic [31:0] data;
    if (v.isWrite) begin
      axiWrite(v.addr, v.data, v.strb, v.awDelay, v.wDelay, v.xDelay, resp, pulse);
      checkOutput($sformatf("vec%0d_bresp", n), 32'(resp), 32'(v.expResp));
      checkOutput($sformatf("vec%0d_pulse", n), 32'(pulse), 32'(v.expPulse));
    end else begin
      axiRead(v.addr, v.xDelay, data, resp);
      checkOutput($sformatf("vec%0d_rresp", n), 32'(resp), 32'(v.expResp));
      checkOutput($sformatf("vec%0d_rdata", n), data, v.expData);
    end
  endtask

  task automatic doReset();
    resetN = 1'b0;
    tick();
    tick();
    checkOutput("rst_awready", 32'(awReady), 32'h0);
    checkOutput("rst_wready", 32'(wReady), 32'h0);
    checkOutput("rst_arready", 32'(arReady), 32'h0);
    checkOutput("rst_valids", 32'({bValid, rValid}), 32'h0);
    checkOutput("rst_resps", 32'({bResp, rResp}), 32'h0);
    checkOutput("rst_rdata", rData, 32'h0);
    checkOutput("rst_pulse", 32'(wrPulse), 32'h0);
    for (int i = 0; i < NR; i++) checkOutput($sformatf("rst_reg%0d", i), regOf(i), 32'h0);
    resetN = 1'b1;
    #1;
    checkOutput("post_rst_readies", 32'({awReady, wReady, arReady}), 32'h7);
  endtask

  initial begin
    logic [1:0] resp;
    logic [3:0] pulse;
    logic [31:0] data, mask;
    int op, idx;
    bit oor;

    resetN = 1'b0; awAddr = '0; awValid = 0; wData = '0; wStrb = '0; wValid = 0; bReady = 0;
    arAddr = '0; arValid = 0; rReady = 0; hwWe = 0; hwIdx = '0; hwWdata = '0;
    doReset();

    vecs.push_back(mkWrite(6'h00, 32'h1, 4'hF, 0, 0, 0, OKAY, 4'b0001));
    vecs.push_back(mkWrite(6'h04, 32'h2, 4'hF, 1, 0, 0, OKAY, 4'b0010));
    vecs.push_back(mkWrite(6'h08, 32'h3, 4'hF, 0, 2, 1, OKAY, 4'b0100));
    vecs.push_back(mkWrite(6'h0C, 32'h4, 4'hF, 0, 0, 2, OKAY, 4'b1000));
    vecs.push_back(mkRead(6'h00, 0, OKAY, 32'h1));
    vecs.push_back(mkRead(6'h04, 1, OKAY, 32'h2));
    vecs.push_back(mkRead(6'h08, 0, OKAY, 32'h3));
    vecs.push_back(mkRead(6'h0C, 2, OKAY, 32'h4));
    vecs.push_back(mkWrite(6'h04, 32'h11223344, 4'hF, 0, 0, 0, OKAY, 4'b0010));
    vecs.push_back(mkWrite(6'h04, 32'hAABBCCDD, 4'b0101, 0, 0, 0, OKAY, 4'b0010));
    vecs.push_back(mkRead(6'h04, 0, OKAY, 32'h11BB33DD));
    vecs.push_back(mkWrite(6'h08, 32'hA5A5A5A5, 4'hF, 3, 0, 0, OKAY, 4'b0100));
    vecs.push_back(mkRead(6'h08, 0, OKAY, 32'hA5A5A5A5));
    vecs.push_back(mkWrite(6'h01, 32'h77, 4'hF, 0, 0, 0, OKAY, 4'b0001));
    vecs.push_back(mkRead(6'h03, 0, OKAY, 32'h77));
`ifdef DIJKSTRA_AXIL_SLVERR_EN
    vecs.push_back(mkWrite(6'h20, 32'hDEADBEEF, 4'hF, 0, 0, 1, SLVERR, 4'b0000));
    vecs.push_back(mkRead(6'h20, 1, SLVERR, 32'h0));
    vecs.push_back(mkRead(6'h00, 0, OKAY, 32'h77));
    vecs.push_back(mkRead(6'h3C, 0, SLVERR, 32'h0));
`else
    vecs.push_back(mkWrite(6'h20, 32'hDEADBEEF, 4'hF, 0, 0, 1, OKAY, 4'b0001));
    vecs.push_back(mkRead(6'h20, 1, OKAY, 32'hDEADBEEF));
    vecs.push_back(mkRead(6'h00, 0, OKAY, 32'hDEADBEEF));
    vecs.push_back(mkRead(6'h3C, 0, OKAY, 32'h4));
`endif
    vecs.push_back(mkWrite(6'h0C, 32'hFFFF0000, 4'b1100, 0, 0, 0, OKAY, 4'b1000));
    vecs.push_back(mkRead(6'h0C, 0, OKAY, 32'hFFFF0004));
    for (int n = 0; n < vecs.size(); n++) applyStimulus(vecs[n], n);

    // W leads AW by three cycles.
    wData = 32'h12345678; wStrb = 4'hF; wValid = 1; bReady = 1;
    tick();
    wValid = 0;
    #1;
    checkOutput("ord_wready_low", 32'(wReady), 32'h0);
    checkOutput("ord_no_bvalid", 32'(bValid), 32'h0);
    tick(); tick();
    awAddr = 6'h08; awValid = 1;
    tick();
    awValid = 0;
    checkOutput("ord_bvalid", 32'({bValid, bResp}), 32'({1'b1, OKAY}));
    checkOutput("ord_pulse", 32'(wrPulse), 32'h4);
    checkOutput("ord_reg2", regOf(2), 32'h12345678);
    checkOutput("ord_wready_back", 32'(wReady), 32'h1);
    tick();
    checkOutput("ord_bvalid_drop", 32'(bValid), 32'h0);

    // Write response backpressure with a second write queued behind it.
    bReady = 0; awAddr = 6'h00; wData = 32'hCAFE0001; awValid = 1; wValid = 1;
    tick();
    checkOutput("bp_first_pulse", 32'(wrPulse), 32'h1);
    checkOutput("bp_first_reg0", regOf(0), 32'hCAFE0001);
    awAddr = 6'h04; wData = 32'hCAFE0002;
    tick();
    awValid = 0; wValid = 0;
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_hold_b", 32'({bValid, bResp}), 32'({1'b1, OKAY}));
      checkOutput("bp_readies_low", 32'({awReady, wReady}), 32'h0);
      checkOutput("bp_reg1_old", regOf(1), 32'h11BB33DD);
      checkOutput("bp_no_pulse", 32'(wrPulse), 32'h0);
      tick();
    end
    bReady = 1;
    tick();
    checkOutput("bp_second_b", 32'(bValid), 32'h1);
    checkOutput("bp_second_pulse", 32'(wrPulse), 32'h2);
    checkOutput("bp_second_reg1", regOf(1), 32'hCAFE0002);
    checkOutput("bp_readies_back", 32'({awReady, wReady}), 32'h3);
    tick();
    bReady = 0;
    checkOutput("bp_drained", 32'(bValid), 32'h0);

    // Read data backpressure with a second AR waiting.
    arAddr = 6'h08; arValid = 1; rReady = 0;
    tick();
    arAddr = 6'h0C;
    for (int i = 0; i < 5; i++) begin
      checkOutput("rbp_hold", rData, 32'h12345678);
      checkOutput("rbp_valid", 32'({rValid, rResp}), 32'({1'b1, OKAY}));
      checkOutput("rbp_arready_low", 32'(arReady), 32'h0);
      tick();
    end
    rReady = 1;
    #1;
    checkOutput("rbp_arready_back", 32'(arReady), 32'h1);
    tick();
    arValid = 0;
    checkOutput("rbp_second", rData, 32'hFFFF0004);
    tick();
    checkOutput("rbp_drained", 32'(rValid), 32'h0);

    // Back-to-back writes, then back-to-back reads.
    bReady = 1; awValid = 1; wValid = 1; wStrb = 4'hF;
    for (int i = 0; i < 3; i++) begin
      awAddr = 6'(4 * i); wData = 32'(256 * (i + 1));
      #1;
      checkOutput("b2b_ready", 32'({awReady, wReady}), 32'h3);
      tick();
      checkOutput("b2b_pulse", 32'(wrPulse), 32'(1 << i));
      checkOutput("b2b_reg", regOf(i), 32'(256 * (i + 1)));
    end
    awValid = 0; wValid = 0;
    tick();
    checkOutput("b2b_b_drop", 32'({bValid, wrPulse}), 32'h0);
    arValid = 1;
    for (int i = 0; i < 3; i++) begin
      arAddr = 6'(4 * i);
      tick();
      checkOutput("b2b_rdata", rData, 32'(256 * (i + 1)));
    end
    arValid = 0;
    tick();
    rReady = 0;
    checkOutput("b2b_r_drop", 32'(rValid), 32'h0);

    // Core write colliding with AXI commits.
    awAddr = 6'h0C; wData = 32'h5; awValid = 1; wValid = 1;
    hwWe = 1; hwIdx = 2'd3; hwWdata = 32'h9;
    tick();
    awValid = 0; wValid = 0; hwWe = 0;
    checkOutput("coll_same_reg3", regOf(3), 32'h5);
    checkOutput("coll_same_pulse", 32'(wrPulse), 32'h8);
    tick();
    awValid = 1; wValid = 1; hwWe = 1; hwIdx = 2'd0;
    tick();
    awValid = 0; wValid = 0; hwWe = 0;
    checkOutput("coll_diff_reg0", regOf(0), 32'h9);
    checkOutput("coll_diff_reg3", regOf(3), 32'h5);
    tick();
    hwWe = 1; hwIdx = 2'd2; hwWdata = 32'hABCD;
    tick();
    hwWe = 0;
    checkOutput("hw_only_reg2", regOf(2), 32'hABCD);
    checkOutput("hw_only_no_pulse", 32'({bValid, wrPulse}), 32'h0);

    // Same-edge read and write of reg1 returns the old value.
    awAddr = 6'h04; wData = 32'h555; awValid = 1; wValid = 1; arAddr = 6'h04; arValid = 1;
    tick();
    awValid = 0; wValid = 0; arValid = 0;
    checkOutput("rw_same_rdata", rData, 32'h200);
    checkOutput("rw_same_reg1", regOf(1), 32'h555);
    rReady = 1;
    tick();
    rReady = 0; bReady = 0;

    // Randomized traffic against the register model.
    doReset();
    for (int i = 0; i < NR; i++) begin model[i] = '0; pulseSeen[i] = 0; pulseExp[i] = 0; end
    for (int it = 0; it < 150; it++) begin
      op = $urandom_range(0, 9);
      if (op < 5) begin
        logic [5:0] a; logic [31:0] d; logic [3:0] s;
        a = 6'($urandom_range(0, 63)); d = $urandom; s = 4'($urandom_range(0, 15));
        idx = modelIdx(a); oor = modelOor(a);
        axiWrite(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), resp, pulse);
        mask = '0;
        for (int k = 0; k < 4; k++) if (s[k]) mask = mask | (32'hFF << (8 * k));
        if (!oor) begin
          model[idx] = (model[idx] & ~mask) | (d & mask);
          pulseExp[idx]++;
        end
        checkOutput("rnd_bresp", 32'(resp), oor ? 32'(SLVERR) : 32'(OKAY));
        checkOutput("rnd_pulse", 32'(pulse), oor ? 32'h0 : 32'(1 << idx));
      end else if (op < 8) begin
        logic [5:0] a;
        a = 6'($urandom_range(0, 63));
        idx = modelIdx(a); oor = modelOor(a);
        axiRead(a, $urandom_range(0, 2), data, resp);
        checkOutput("rnd_rresp", 32'(resp), oor ? 32'(SLVERR) : 32'(OKAY));
        checkOutput("rnd_rdata", data, oor ? 32'h0 : model[idx]);
      end else begin
        idx = $urandom_range(0, NR - 1);
        hwWe = 1; hwIdx = 2'(idx); hwWdata = $urandom;
        model[idx] = hwWdata;
        tick();
        hwWe = 0;
      end
      for (int i = 0; i < NR; i++) checkOutput($sformatf("rnd_reg%0d", i), regOf(i), model[i]);
    end
    tick();
    for (int i = 0; i < NR; i++) checkOutput($sformatf("rnd_pulse_count%0d", i), 32'(pulseSeen[i]), 32'(pulseExp[i]));

    // Reset in the middle of a write: the captured address is dropped.
    axiWrite(6'h04, 32'h1234, 4'hF, 0, 0, 0, resp, pulse);
    checkOutput("mid_pre_reg1", regOf(1), 32'h1234);
    awAddr = 6'h04; awValid = 1;
    tick();
    awValid = 0;
    doReset();
    wData = 32'h99; wStrb = 4'hF; wValid = 1; bReady = 0;
    tick();
    wValid = 0;
    tick(); tick();
    checkOutput("mid_no_bvalid", 32'(bValid), 32'h0);
    checkOutput("mid_reg1", regOf(1), 32'h0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule
